// File: rtl/lr_car_detector.sv
// Local-road loop sensor front end: synchronize, debounce, count waiting cars, raise lr_has_car.
// Optional stuck-sensor detection is compiled in with `define LR_STUCK_DETECT_EN.
`timescale 1ns/1ps
module lr_car_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic [2:0]       lr_light,
  output logic             lr_has_car,
  output logic [CNT_W-1:0] lr_wait_cnt,
  output logic             sensor_fault
);

  localparam int unsigned  DB_CNT_W = 8;
  localparam logic [DB_CNT_W-1:0] DB_TGT = DB_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [2:0]   LIGHT_GREEN = 3'b100;
  localparam logic [CNT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_QUAL = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_QUAL = 2'd3
  } db_state_e;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES < 1) begin : g_bad_param
    $error("lr_car_detector: DEBOUNCE_CYCLES must be 1..255 and STUCK_CYCLES >= 1");
  end

  logic                sync_q1, sync_q2;
  db_state_e           state_q, state_d;
  logic [DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic                arrival_q, arrival_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                has_car_q, has_car_d;
  logic                db_level;
  logic                lr_green;
  logic                fault;

  // Two-flop synchronizer; the only consumer of sensor_raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sensor_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOW;
      db_cnt_q  <= '0;
      arrival_q <= 1'b0;
      wait_q    <= '0;
      has_car_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      arrival_q <= arrival_d;
      wait_q    <= wait_d;
      has_car_q <= has_car_d;
    end
  end

  assign db_level = (state_q == ST_HIGH) || (state_q == ST_FALL_QUAL);
  assign lr_green = (lr_light == LIGHT_GREEN);

  // Debounce FSM: D consecutive opposite samples are needed to flip the level.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      ST_LOW: begin
        if (sync_q2) begin
          if (DB_TGT == DB_CNT_W'(1)) begin
            state_d = ST_HIGH;
          end else begin
            state_d  = ST_RISE_QUAL;
            db_cnt_d = DB_CNT_W'(1);
          end
        end
      end
      ST_RISE_QUAL: begin
        if (!sync_q2) begin
          state_d  = ST_LOW;
          db_cnt_d = '0;
        end else if (db_cnt_q + DB_CNT_W'(1) >= DB_TGT) begin
          state_d  = ST_HIGH;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync_q2) begin
          if (DB_TGT == DB_CNT_W'(1)) begin
            state_d = ST_LOW;
          end else begin
            state_d  = ST_FALL_QUAL;
            db_cnt_d = DB_CNT_W'(1);
          end
        end
      end
      ST_FALL_QUAL: begin
        if (sync_q2) begin
          state_d  = ST_HIGH;
          db_cnt_d = '0;
        end else if (db_cnt_q + DB_CNT_W'(1) >= DB_TGT) begin
          state_d  = ST_LOW;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_LOW;
        db_cnt_d = '0;
      end
    endcase
  end

  // Arrival only on a genuine low-to-high; a FALL_QUAL glitch returning to HIGH is not a new car.
  always_comb begin
    arrival_d = (state_d == ST_HIGH) && !db_level;
    wait_d    = wait_q;
    if (lr_green) begin
      wait_d = '0;
    end else if (arrival_q && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + CNT_W'(1);
    end
    has_car_d = (wait_d != '0) || (db_level && !lr_green) || fault;
  end

`ifdef LR_STUCK_DETECT_EN
  localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_TGT = STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] stuck_q, stuck_d;
  logic               fault_q, fault_d;

  // Fault latches until reset so the side road keeps being served.
  always_comb begin
    stuck_d = '0;
    if (db_level) begin
      stuck_d = (stuck_q == STUCK_TGT) ? stuck_q : stuck_q + STUCK_W'(1);
    end
    fault_d = fault_q || (stuck_d == STUCK_TGT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign lr_has_car   = has_car_q;
  assign lr_wait_cnt  = wait_q;
  assign sensor_fault = fault;

endmodule

// File: doc/lr_car_detector.md
# lr_car_detector

Front end for the side-road request input of the traffic light controller. Synchronizes and debounces the raw local-road loop sensor and counts cars arriving while the local road is not green. Produces the registered `lr_has_car` request that the controller consumes, and takes the controller's `lr_light` output back so it can clear the request once the local road is served.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronized samples required to change the debounced level; legal range 1–255.
- `CNT_W`, default 4: width of the waiting-car counter.
- `STUCK_CYCLES`, default 1000: debounced-high duration that flags a stuck sensor. Used only with `LR_STUCK_DETECT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sensor_raw` input 1: raw loop sensor, asynchronous to `clk`, may bounce.
- `lr_light` input 3: local-road light from the controller, encoded {green, yellow, red}. Green is 3'b100, yellow is 3'b010, red is 3'b001.
- `lr_has_car` output 1: registered request to the controller.
- `lr_wait_cnt` output CNT_W: number of cars waiting, saturating.
- `sensor_fault` output 1: stuck-sensor flag. Tied 0 when the feature is compiled out.

## Operation
- **Synchronizer:** two flops, `sensor_raw` to `sync_q1` to `sync_q2`. Nothing else samples `sensor_raw`.
- **Debounce FSM:** states are LOW, RISE_QUAL, HIGH, FALL_QUAL. It keeps a stability counter of 8 bits.
  - LOW: `sync_q2`=1 goes to RISE_QUAL with cnt=1. If DEBOUNCE_CYCLES==1, it goes straight to HIGH.
  - RISE_QUAL: `sync_q2`=1 increments cnt. When cnt reaches DEBOUNCE_CYCLES it goes to HIGH. `sync_q2`=0 returns to LOW.
  - HIGH and FALL_QUAL mirror LOW and RISE_QUAL with the polarity inverted.
  - `db_level` is 1 in HIGH and FALL_QUAL.
- **Arrival:** a one-cycle pulse on the transition into HIGH.
- **Green detect:** `lr_green` is `lr_light==3'b100`. Any other value, including illegal encodings, counts as not green.
- **Waiting counter `lr_wait_cnt`:**
  - While `lr_green`, it is cleared to 0.
  - Otherwise, each arrival adds 1, saturating at 2^CNT_W−1.
  - An arrival in the same cycle as `lr_green` is dropped; the clear wins.
- **Request:** `lr_has_car` next-state is (next `lr_wait_cnt` != 0) OR (`db_level` AND NOT `lr_green`) OR `sensor_fault`.
  - The request therefore holds while a car is stopped on the loop.
  - It also holds after a car leaves the loop, until green is seen.

## Timing
- Reset: `sync_q1`, `sync_q2` and `db_level` are 0; the FSM is in LOW; counters are 0; `lr_has_car`, `lr_wait_cnt` and `sensor_fault` are 0. Reset takes effect asynchronously; release is synchronous to `clk`.
- Reset mid-qualification or mid-count discards all state. No request survives reset.
- Latency, with E0 being the first edge that samples `sensor_raw`=1 stable:
  - `sync_q2` is high after E1.
  - `db_level` is high after E(1+D).
  - `lr_has_car` and `lr_wait_cnt` update after E(2+D).
  - With D=4, `lr_has_car` rises after E6.
- Release: the debounce side mirrors the rise latency. With `lr_wait_cnt`=0, `lr_has_car` falls one edge after `lr_green` is sampled.
- `lr_light` is synchronous to `clk` and is used unsynchronized.
- Bounces shorter than D samples never change `db_level`.

## Configuration
- `LR_STUCK_DETECT_EN` defined:
  - A stuck counter increments while `db_level`=1 and clears when `db_level`=0. It saturates at STUCK_CYCLES.
  - On reaching STUCK_CYCLES, `sensor_fault` is set on that edge and stays set until `rst_n` is asserted.
  - While `sensor_fault`=1, `lr_has_car` is forced to 1 (fail-safe service of the side road).
- `LR_STUCK_DETECT_EN` undefined: no stuck counter, `sensor_fault` is constant 0, and the request logic omits that term.

## Test plan
- Clean pulse: with D=4 and `lr_light`=red, `sensor_raw` goes high at E0 and holds 10 cycles.
  - `lr_has_car` rises after E6.
  - `lr_wait_cnt` becomes 1.
  - Both hold after `sensor_raw` falls, until `lr_light`=3'b100 is sampled; both are 0 one edge later.
- Bounce rejection: `sensor_raw` toggles 1,0,1,0,1,0 (one cycle each), then stays 0. `db_level`, `lr_has_car` and `lr_wait_cnt` stay 0 throughout.
- Counting and saturation: with CNT_W=4 and red, 20 clean arrivals separated by 12-cycle gaps. `lr_wait_cnt` reaches 15 and stays at 15. A green then clears it to 0.
- Arrival during green and simultaneous events: arrivals while `lr_light`=3'b100 leave `lr_wait_cnt`=0. An arrival on the same edge green is first sampled also leaves `lr_wait_cnt`=0.
- Async reset mid-operation: drop `rst_n` during RISE_QUAL, and separately with `lr_wait_cnt`=3. All outputs are 0 immediately, with no clock edge required. After release, a fresh arrival again takes D+3 edges.
- Stuck sensor, `LR_STUCK_DETECT_EN` with STUCK_CYCLES=50: hold `sensor_raw` high.
  - `sensor_fault` rises 50 edges after `db_level` rises.
  - `lr_has_car` stays 1 even during green.
  - Only `rst_n` clears the fault.
  - Without the macro, `sensor_fault` stays 0.
